// File: rtl/gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gpr_wb_arbiter
// Purpose  : Round-robin writeback arbiter between the ALU and the LSU for the
//            general-purpose register file. The winner's result is registered
//            and written (one cycle later), a commit pulse with the PC is
//            exported, a retired-instruction counter is kept, and a 32-entry
//            pending-write scoreboard is maintained.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   alu_valid/ready     : ALU writeback handshake (rd, data, pc payload)
//   lsu_valid/ready     : LSU load-return handshake (rd, data, pc payload)
//   mark_valid/mark_rd  : issue stage reserves a destination register
//   rf_wen/waddr/wdata  : GPR write port (never writes x0)
//   commit_valid/pc     : one instruction retired, with its PC
//   pending             : scoreboard, bit i = register i has a write in flight
//   commit_cnt          : 64-bit retired-instruction counter
// ============================================================================
module gpr_wb_arbiter #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,

   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic [XLEN-1:0] alu_pc,

   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   input  logic [XLEN-1:0] lsu_pc,

   input  logic            mark_valid,
   input  logic [4:0]      mark_rd,

   output logic            rf_wen,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,

   output logic            commit_valid,
   output logic [XLEN-1:0] commit_pc,

   output logic [31:0]     pending,
   output logic [63:0]     commit_cnt
);

   // Identity of the requester that won the most recent contested grant.
   typedef enum logic {
      RR_ALU = 1'b0,
      RR_LSU = 1'b1
   } rr_t;

   rr_t             rr_last;
   logic            wen_q;
   logic            commit_q;
   logic [4:0]      waddr_q;
   logic [XLEN-1:0] wdata_q;
   logic [XLEN-1:0] pc_q;
   logic [31:0]     pending_q;
   logic [63:0]     cnt_q;

   logic            alu_hs;
   logic            lsu_hs;
   logic            hs;
   logic            contested;
   logic [4:0]      hs_rd;
   logic [XLEN-1:0] hs_data;
   logic [XLEN-1:0] hs_pc;
   logic [31:0]     set_mask;
   logic [31:0]     clr_mask;
   logic [31:0]     pending_next;

   // ------------------------------------------------------------------------
   // Grant: purely a function of the valids, reset and the round-robin bit.
   // ------------------------------------------------------------------------
   assign contested = alu_valid && lsu_valid;

   always_comb begin
      alu_ready = 1'b0;
      lsu_ready = 1'b0;
      if (rst_n) begin
         if (contested) begin
            // The side that lost the previous contest wins this one.
            if (rr_last == RR_ALU) begin
               lsu_ready = 1'b1;
            end else begin
               alu_ready = 1'b1;
            end
         end else begin
            alu_ready = alu_valid;
            lsu_ready = lsu_valid;
         end
      end
   end

   assign alu_hs  = alu_valid && alu_ready;
   assign lsu_hs  = lsu_valid && lsu_ready;
   assign hs      = alu_hs || lsu_hs;

   assign hs_rd   = lsu_hs ? lsu_rd   : alu_rd;
   assign hs_data = lsu_hs ? lsu_data : alu_data;
   assign hs_pc   = lsu_hs ? lsu_pc   : alu_pc;

   // ------------------------------------------------------------------------
   // Scoreboard: the set is OR-ed in after the clear, so a reservation of a
   // register that is retiring in the same cycle survives. Bit 0 is tied off.
   // ------------------------------------------------------------------------
   always_comb begin
      set_mask = 32'd0;
      clr_mask = 32'd0;
      if (mark_valid) begin
         set_mask = 32'd1 << mark_rd;
      end
      if (hs) begin
         clr_mask = 32'd1 << hs_rd;
      end
      pending_next    = (pending_q & ~clr_mask) | set_mask;
      pending_next[0] = 1'b0;
   end

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_last   <= RR_ALU;
         wen_q     <= 1'b0;
         commit_q  <= 1'b0;
         waddr_q   <= 5'd0;
         wdata_q   <= '0;
         pc_q      <= '0;
         pending_q <= 32'd0;
         cnt_q     <= 64'd0;
      end else begin
         wen_q     <= hs && (hs_rd != 5'd0);
         commit_q  <= hs;
         pending_q <= pending_next;
         if (hs) begin
            waddr_q <= hs_rd;
            wdata_q <= hs_data;
            pc_q    <= hs_pc;
            cnt_q   <= cnt_q + 64'd1;
         end
         if (contested) begin
            rr_last <= alu_hs ? RR_ALU : RR_LSU;
         end
      end
   end

   // The write/commit strobes are masked by rst_n so that a result captured
   // just before reset asserts never produces a pulse while reset is low.
   assign rf_wen       = wen_q && rst_n;
   assign commit_valid = commit_q && rst_n;
   assign rf_waddr     = waddr_q;
   assign rf_wdata     = wdata_q;
   assign commit_pc    = pc_q;
   assign pending      = pending_q;
   assign commit_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpr_wb_arbiter
// Purpose  : Directed self-checking bench for gpr_wb_arbiter. Inputs change
//            1 ns after the rising edge; outputs are sampled well clear of it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_wb_arbiter;

   localparam int XLEN = 64;

   logic            clk;
   logic            rst_n;
   logic            alu_valid;
   logic            alu_ready;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic [XLEN-1:0] alu_pc;
   logic            lsu_valid;
   logic            lsu_ready;
   logic [4:0]      lsu_rd;
   logic [XLEN-1:0] lsu_data;
   logic [XLEN-1:0] lsu_pc;
   logic            mark_valid;
   logic [4:0]      mark_rd;
   logic            rf_wen;
   logic [4:0]      rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic            commit_valid;
   logic [XLEN-1:0] commit_pc;
   logic [31:0]     pending;
   logic [63:0]     commit_cnt;

   int checks = 0;
   int errors = 0;

   gpr_wb_arbiter #(.XLEN(XLEN)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .alu_pc       (alu_pc),
      .lsu_valid    (lsu_valid),
      .lsu_ready    (lsu_ready),
      .lsu_rd       (lsu_rd),
      .lsu_data     (lsu_data),
      .lsu_pc       (lsu_pc),
      .mark_valid   (mark_valid),
      .mark_rd      (mark_rd),
      .rf_wen       (rf_wen),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .commit_valid (commit_valid),
      .commit_pc    (commit_pc),
      .pending      (pending),
      .commit_cnt   (commit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid  = 1'b0;
      lsu_valid  = 1'b0;
      mark_valid = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0; alu_pc = '0;
      lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = '0; lsu_pc = '0;
      mark_valid = 1'b0; mark_rd = 5'd0;
      tick();

      // ---- reset state; ready held low while in reset ----
      alu_valid = 1'b1; lsu_valid = 1'b1; alu_rd = 5'd1; lsu_rd = 5'd2;
      #2;
      chk("rst_alu_ready", 64'(alu_ready), 64'd0);
      chk("rst_lsu_ready", 64'(lsu_ready), 64'd0);
      tick();
      chk("rst_wen",     64'(rf_wen), 64'd0);
      chk("rst_commit",  64'(commit_valid), 64'd0);
      chk("rst_waddr",   64'(rf_waddr), 64'd0);
      chk("rst_wdata",   rf_wdata, 64'd0);
      chk("rst_pc",      commit_pc, 64'd0);
      chk("rst_pending", 64'(pending), 64'd0);
      chk("rst_cnt",     commit_cnt, 64'd0);
      idle();
      rst_n = 1'b1;
      tick();

      // ---- single ALU write ----
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234; alu_pc = 64'h8000_0000;
      #1;
      chk("single_alu_ready", 64'(alu_ready), 64'd1);
      chk("single_lsu_ready", 64'(lsu_ready), 64'd0);
      tick();
      idle();
      chk("single_wen",    64'(rf_wen), 64'd1);
      chk("single_waddr",  64'(rf_waddr), 64'd5);
      chk("single_wdata",  rf_wdata, 64'h1234);
      chk("single_commit", 64'(commit_valid), 64'd1);
      chk("single_pc",     commit_pc, 64'h8000_0000);
      chk("single_cnt",    commit_cnt, 64'd1);
      tick();
      chk("idle_wen",    64'(rf_wen), 64'd0);
      chk("idle_commit", 64'(commit_valid), 64'd0);
      chk("idle_waddr",  64'(rf_waddr), 64'd5);
      chk("idle_wdata",  rf_wdata, 64'h1234);
      chk("idle_pc",     commit_pc, 64'h8000_0000);

      // ---- contention after reset: LSU, ALU, LSU ----
      do_reset();
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'hA1; alu_pc = 64'h100;
      lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 64'hB2; lsu_pc = 64'h200;
      #1;
      chk("cont1_lsu_ready", 64'(lsu_ready), 64'd1);
      chk("cont1_alu_ready", 64'(alu_ready), 64'd0);
      tick();
      chk("cont1_waddr", 64'(rf_waddr), 64'd2);
      chk("cont1_wdata", rf_wdata, 64'hB2);
      lsu_rd = 5'd3; lsu_data = 64'hB3; lsu_pc = 64'h300;
      #1;
      chk("cont2_alu_ready", 64'(alu_ready), 64'd1);
      chk("cont2_lsu_ready", 64'(lsu_ready), 64'd0);
      tick();
      chk("cont2_waddr", 64'(rf_waddr), 64'd1);
      chk("cont2_wdata", rf_wdata, 64'hA1);
      chk("cont2_pc",    commit_pc, 64'h100);
      alu_rd = 5'd4; alu_data = 64'hA4; alu_pc = 64'h400;
      #1;
      chk("cont3_lsu_ready", 64'(lsu_ready), 64'd1);
      tick();
      idle();
      chk("cont3_waddr", 64'(rf_waddr), 64'd3);
      chk("cont3_wdata", rf_wdata, 64'hB3);
      chk("cont3_pc",    commit_pc, 64'h300);
      chk("cont_cnt",    commit_cnt, 64'd3);

      // ---- x0 write ----
      do_reset();
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 64'hFFFF; lsu_pc = 64'h500;
      tick();
      idle();
      chk("x0_wen",    64'(rf_wen), 64'd0);
      chk("x0_commit", 64'(commit_valid), 64'd1);
      chk("x0_pc",     commit_pc, 64'h500);
      chk("x0_cnt",    commit_cnt, 64'd1);

      // ---- scoreboard ----
      mark_valid = 1'b1; mark_rd = 5'd7;
      tick();
      chk("sb_set7", 64'(pending), 64'h80);
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h77; alu_pc = 64'h600;
      tick();
      chk("sb_set_wins", 64'(pending), 64'h80);
      mark_rd = 5'd9;
      tick();
      chk("sb_set_clr_diff", 64'(pending), 64'h200);
      mark_rd = 5'd0; alu_valid = 1'b0;
      tick();
      chk("sb_mark_x0", 64'(pending), 64'h200);
      mark_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd12;
      tick();
      chk("sb_clr_unset", 64'(pending), 64'h200);
      alu_rd = 5'd9;
      tick();
      idle();
      chk("sb_clr9", 64'(pending), 64'h0);

      // ---- reset mid-flight ----
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33; alu_pc = 64'h700;
      mark_valid = 1'b1; mark_rd = 5'd4;
      tick();
      idle();
      rst_n = 1'b0;
      #1;
      chk("mid_wen_n1", 64'(rf_wen), 64'd0);
      tick();
      chk("mid_wen_rst", 64'(rf_wen), 64'd0);
      chk("mid_pending", 64'(pending), 64'd0);
      chk("mid_cnt",     commit_cnt, 64'd0);
      rst_n = 1'b1;
      tick();
      chk("mid_wen_after", 64'(rf_wen), 64'd0);

      // ---- counter wrap ----
      force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.cnt_q;
      chk("wrap_preload", commit_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
      lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 64'h88; lsu_pc = 64'h800;
      tick();
      idle();
      chk("wrap_cnt", commit_cnt, 64'd0);
      chk("wrap_wen", 64'(rf_wen), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gpr_wb_arbiter.md
GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 64, data and PC width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 alu_valid  in  1  ALU writeback request.
REQ-005 alu_ready  out  1  ALU request granted this cycle.
REQ-006 alu_rd  in  5  ALU destination register.
REQ-007 alu_data  in  XLEN  ALU result.
REQ-008 alu_pc  in  XLEN  PC of the ALU instruction.
REQ-009 lsu_valid, lsu_ready, lsu_rd, lsu_data, lsu_pc: same widths and meanings as the alu_* ports, for load returns.
REQ-010 mark_valid  in  1  issue stage reserves a destination register.
REQ-011 mark_rd  in  5  register being reserved.
REQ-012 rf_wen  out  1  GPR write enable.
REQ-013 rf_waddr  out  5  GPR write address.
REQ-014 rf_wdata  out  XLEN  GPR write data.
REQ-015 commit_valid  out  1  one instruction retired (drives PC/GPR export to simulator).
REQ-016 commit_pc  out  XLEN  PC of the retired instruction.
REQ-017 pending  out  32  scoreboard: bit i = register i has an outstanding write.
REQ-018 commit_cnt  out  64  retired-instruction counter.

Function
REQ-019 A handshake occurs on a requester when its valid and ready are both 1 in the same cycle; at most one handshake per cycle.
REQ-020 ready is combinational from the valids and the round-robin pointer; it does not depend on ready.
REQ-021 Only one valid: that requester gets ready=1.
REQ-022 Both valid: the requester not granted at the last contested grant wins.
REQ-023 rr_last (1 bit) updates only on contested grants, to the winner.
REQ-024 Requesters hold valid, rd, data, and pc stable until their handshake; the arbiter does not buffer unaccepted requests.
REQ-025 Latency is 1 cycle: a handshake in cycle N registers rd/data/pc; rf_wen, rf_waddr, rf_wdata, commit_valid, and commit_pc are valid in cycle N+1 only.
REQ-026 rd=0: commit_valid=1 and commit_pc is updated, but rf_wen=0; x0 is never written.
REQ-027 No handshake in cycle N: rf_wen=0 and commit_valid=0 in N+1; rf_waddr, rf_wdata, and commit_pc hold their last values.
REQ-028 commit_cnt increments by 1 for every handshake, visible in N+1, and wraps modulo 2^64.
REQ-029 Scoreboard set: mark_valid with mark_rd != 0 sets pending[mark_rd] in the next cycle.
REQ-030 Scoreboard clear: a handshake with rd clears pending[rd] in the next cycle.
REQ-031 Set and clear of the same rd in the same cycle: set wins; bit is 1 in the next cycle.
REQ-032 Set and clear of different registers in the same cycle both take effect.
REQ-033 mark_rd=0 is ignored; pending[0] is constant 0.
REQ-034 A clear of a bit that is not set is harmless; the bit stays 0.

Reset
REQ-035 rst_n=0 at a rising edge forces: rf_wen=0, commit_valid=0, rf_waddr=0, rf_wdata=0, commit_pc=0, pending=0, commit_cnt=0, rr_last=ALU (first contested grant goes to LSU).
REQ-036 During reset, alu_ready and lsu_ready are 0.
REQ-037 A handshake that coincides with reset is discarded.
REQ-038 Reset mid-operation discards the in-flight registered write; no rf_wen pulse follows reset.

Verification
REQ-039 Single ALU: alu_valid=1, rd=5, data=0x1234, pc=0x80000000 in cycle 1 -> alu_ready=1 in cycle 1; cycle 2 shows rf_wen=1, waddr=5, wdata=0x1234, commit_pc=0x80000000, commit_cnt=1.
REQ-040 Contention after reset: both valid for 3 cycles with distinct rd -> grants in order LSU, ALU, LSU; commit_cnt=3; the loser's payload is unchanged until its grant.
REQ-041 x0 write: lsu_valid=1, rd=0, data=0xFFFF -> next cycle rf_wen=0, commit_valid=1, commit_cnt=1.
REQ-042 Scoreboard collision: pending[7]=1; same cycle mark_rd=7 and ALU handshake rd=7 -> pending[7]=1 next cycle; a later ALU rd=7 handshake -> pending[7]=0.
REQ-043 Reset mid-flight: handshake in cycle N, rst_n=0 in cycle N+1 -> no rf_wen pulse at N+1 or after; pending=0, commit_cnt=0 after reset.
REQ-044 Wrap: commit_cnt forced to 0xFFFF_FFFF_FFFF_FFFF, one handshake -> commit_cnt=0.
